// File: rtl/wbm_uart_sched_pkg.sv
// Shared encodings and sizing helpers for the wishbone UART scheduler.
package wbm_uart_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int FRAME_BITS_DEF = 10;

  // Width able to hold 0..pace; never narrower than one bit.
  function automatic int pace_width(input int pace);
    int w;
    w = $clog2(pace + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wbm_uart_rr_arbiter.sv
// Round-robin arbiter with packet lock: the owner keeps the grant until its
// last byte is taken, then the pointer moves to the next index.
module wbm_uart_rr_arbiter
  import wbm_uart_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] valid_i,
  input  logic [N_REQ-1:0] last_i,
  input  logic             take_i,
  output logic [IW-1:0]    sel_o,
  output logic             sel_vld_o,
  output logic [N_REQ-1:0] grant_o
);

  logic          lock_q, lock_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] hi_idx, lo_idx, rr_idx;
  logic          hi_hit;
  logic          sel_last;

  // Lowest valid index at/after the pointer, else wrap to lowest valid overall.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_idx = IW'(i);
          hi_hit = 1'b1;
        end
      end
    end
    rr_idx = hi_hit ? hi_idx : lo_idx;
  end

  assign sel_o = lock_q ? own_q : rr_idx;

  always_comb begin
    sel_vld_o = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_o == IW'(i)) begin
        sel_vld_o = valid_i[i];
        sel_last  = last_i[i];
      end
    end
  end

  always_comb begin
    lock_d = lock_q;
    own_d  = own_q;
    ptr_d  = ptr_q;
    if (take_i) begin
      if (sel_last) begin
        lock_d = 1'b0;
        ptr_d  = (sel_o == IW'(N_REQ - 1)) ? '0 : sel_o + IW'(1);
      end else begin
        lock_d = 1'b1;
        own_d  = sel_o;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= 1'b0;
      own_q  <= '0;
      ptr_q  <= '0;
    end else begin
      lock_q <= lock_d;
      own_q  <= own_d;
      ptr_q  <= ptr_d;
    end
  end

  assign grant_o = lock_q ? (N_REQ'(1) << own_q) : '0;

endmodule

// File: rtl/wbm_uart_sched.sv
// Wishbone pipelined master sharing one UART slave among N_REQ TX streams,
// with frame pacing. RX read-back path enabled by WBM_UART_SCHED_RX_EN.
module wbm_uart_sched
  import wbm_uart_sched_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int WB_CLK_HZ  = 0,
  parameter int OUTPUT_HZ  = 9600,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [3:0]         wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  input  logic [31:0]        wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_stall_i,
  input  logic               irq_uart_rx_i,
  output logic               rx_valid_o,
  output logic [7:0]         rx_data_o,
  input  logic               rx_ready_i,
  output logic               rx_overrun_o
);

  localparam int TICKS = WB_CLK_HZ / OUTPUT_HZ;
  localparam int PACE  = TICKS * FRAME_BITS;
  localparam int PW    = pace_width(PACE);
  localparam int IW    = idx_width(N_REQ);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pace_q, pace_d;
  logic          we_q, we_d;
  logic [7:0]    dat_q, dat_d;

  logic [IW-1:0] sel_idx;
  logic          sel_vld;
  logic [7:0]    sel_byte;
  logic          idle, rd_start, wr_start, ack_ev;

  assign idle = (state_q == ST_IDLE);

  wbm_uart_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .valid_i   (req_valid_i),
    .last_i    (req_last_i),
    .take_i    (wr_start),
    .sel_o     (sel_idx),
    .sel_vld_o (sel_vld),
    .grant_o   (grant_o)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IW'(i)) sel_byte = req_data_i[8*i +: 8];
    end
  end

  // Reset gates the accept so req_ready_o stays low while wb_rst_ni is asserted.
  assign wr_start = wb_rst_ni & idle & ~rd_start & (pace_q == '0) & sel_vld;
  assign ack_ev   = wbm_ack_i & (((state_q == ST_REQ) & ~wbm_stall_i) | (state_q == ST_WAIT));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    dat_d   = dat_q;
    pace_d  = (pace_q != '0) ? pace_q - PW'(1) : pace_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          state_d = ST_REQ;
          we_d    = 1'b0;
          dat_d   = 8'h00;
        end else if (wr_start) begin
          state_d = ST_REQ;
          we_d    = 1'b1;
          dat_d   = sel_byte;
        end
      end
      ST_REQ:  if (!wbm_stall_i) state_d = wbm_ack_i ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (wbm_ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ack_ev && we_q) pace_d = PW'(PACE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      pace_q  <= '0;
      we_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pace_q  <= pace_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  end

  assign wbm_cyc_o   = ~idle;
  assign wbm_stb_o   = (state_q == ST_REQ);
  assign wbm_we_o    = we_q & ~idle;
  assign wbm_adr_o   = 4'h0;
  assign wbm_dat_o   = {24'h0, dat_q};
  assign req_ready_o = wr_start ? (N_REQ'(1) << sel_idx) : '0;

`ifdef WBM_UART_SCHED_RX_EN
  logic       irq_q, rx_pend_q, rx_valid_q, ovr_q;
  logic [7:0] rx_data_q;
  logic       irq_rise;
  logic       unused_dat;

  assign irq_rise   = irq_uart_rx_i & ~irq_q;
  // A waiting byte holds off the next read, but never the TX path.
  assign rd_start   = wb_rst_ni & idle & rx_pend_q & ~rx_valid_q;
  assign unused_dat = ^wbm_dat_i[31:8];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q      <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      ovr_q      <= 1'b0;
    end else begin
      irq_q <= irq_uart_rx_i;
      // A new edge while the previous byte is still unread loses that byte.
      ovr_q <= irq_rise & rx_pend_q & ~rd_start;
      if (irq_rise)      rx_pend_q <= 1'b1;
      else if (rd_start) rx_pend_q <= 1'b0;
      if (ack_ev && !we_q) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= wbm_dat_i[7:0];
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign rx_overrun_o = ovr_q;
`else
  logic unused_rx;

  assign rd_start     = 1'b0;
  assign unused_rx    = ^{irq_uart_rx_i, rx_ready_i, wbm_dat_i};
  assign rx_valid_o   = 1'b0;
  assign rx_data_o    = 8'h00;
  assign rx_overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_wbm_uart_sched.sv
// Directed bench for wbm_uart_sched (PACE = 100 cycles); RX checks follow WBM_UART_SCHED_RX_EN.
module tb_wbm_uart_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        cyc, stb, we, ack, stall, irq, rx_valid, rx_ready, rx_ovr;
  logic [3:0]  adr;
  logic [31:0] dat_o, dat_i;
  logic [7:0]  rx_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  always #5 clk = ~clk;

  wbm_uart_sched #(.N_REQ(2), .WB_CLK_HZ(96000), .OUTPUT_HZ(9600), .FRAME_BITS(10)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .grant_o      (grant),
    .wbm_cyc_o    (cyc),
    .wbm_stb_o    (stb),
    .wbm_we_o     (we),
    .wbm_adr_o    (adr),
    .wbm_dat_o    (dat_o),
    .wbm_dat_i    (dat_i),
    .wbm_ack_i    (ack),
    .wbm_stall_i  (stall),
    .irq_uart_rx_i(irq),
    .rx_valid_o   (rx_valid),
    .rx_data_o    (rx_data),
    .rx_ready_i   (rx_ready),
    .rx_overrun_o (rx_ovr)
  );

  // Count strobes the slave accepted.
  always @(posedge clk) begin
    if (rst_n && cyc && stb && !stall) begin
      if (we) wr_cnt++;
      else    rd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (req_ready == 2'b00 && n < 300) begin
      tick();
      n++;
    end
    chk("rdy_timeout", {31'b0, |req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int ia, ib;
    logic [7:0] pa [3];
    logic [7:0] pb [3];
    logic [7:0] ca, cb;
    pa = '{8'hA0, 8'hA1, 8'hA2};
    pb = '{8'hB0, 8'hB1, 8'hB2};
    ack = 0; stall = 0; irq = 0; rx_ready = 0; dat_i = 32'h0;
    req_valid = 2'b01; req_data = 16'h0041; req_last = 2'b01;
    repeat (2) tick();

    // reset state, with a requester already valid
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", we, 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_ovr", rx_ovr, 0);

    // single byte 0x41 on req0
    rst_n = 1; #1;
    chk("t1_rdy", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t1_bus", {cyc, stb, we}, 3'b111);
    chk("t1_dat", dat_o, 32'h41);
    chk("t1_grant", grant, 0);
    ack = 1; tick(); ack = 0;
    chk("t1_idle", cyc, 0);
    chk("t1_wrcnt", wr_cnt, 1);

    // next req0 byte waits out the frame pace
    req_valid = 2'b01; req_data = 16'h0042; req_last = 2'b01; #1;
    chk("t2_pace_blk", req_ready, 0);
    wait_ready(n);
    chk("t2_pace_len", n, 100);
    tick(); req_valid = 2'b00;
    chk("t2_dat", dat_o, 32'h42);
    ack = 1; tick(); ack = 0;

    // req1 byte (RR pointer now 1) with 5 stalled cycles
    req_valid = 2'b10; req_data = 16'h4300; req_last = 2'b10;
    wait_ready(n);
    chk("t3_sel", req_ready, 2'b10);
    tick(); req_valid = 2'b00; stall = 1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_stb_hold", stb, 1);
      chk("t3_dat_hold", dat_o, 32'h43);
      tick();
    end
    stall = 0; tick();
    chk("t3_wait", {cyc, stb}, 2'b10);
    ack = 1; tick(); ack = 0;
    chk("t3_wrcnt", wr_cnt, 3);

    // two competing 3-byte packets
    ia = 0; ib = 0;
    for (int i = 0; i < 6; i++) begin
      ca = (ia < 3) ? pa[ia] : 8'h00;
      cb = (ib < 3) ? pb[ib] : 8'h00;
      req_valid = {ib < 3, ia < 3};
      req_data  = {cb, ca};
      req_last  = {ib == 2, ia == 2};
      if (i == 1) begin
        req_valid[0] = 1'b0;
        repeat (120) tick();
        chk("t4_lock_rdy", req_ready, 0);
        chk("t4_lock_grant", grant, 2'b01);
        req_valid[0] = 1'b1; #1;
      end
      wait_ready(n);
      chk("t4_order", req_ready, (i < 3) ? 2'b01 : 2'b10);
      tick();
      chk("t4_dat", dat_o, {24'h0, (i < 3) ? pa[i % 3] : pb[i % 3]});
      chk("t4_grant", grant, (i < 2) ? 2'b01 : (i == 3 || i == 4) ? 2'b10 : 2'b00);
      if (i < 3) ia++; else ib++;
      ack = 1; tick(); ack = 0;
    end
    chk("t4_wrcnt", wr_cnt, 9);

    // reset while waiting for ack
    req_valid = 2'b01; req_data = 16'h0055; req_last = 2'b00;
    wait_ready(n);
    tick();
    chk("t5_grant_lock", grant, 2'b01);
    tick();
    chk("t5_wait", {cyc, stb}, 2'b10);
    req_data = 16'h0066; req_last = 2'b01;
    rst_n = 0; #1;
    chk("t5_rst_cyc", cyc, 0);
    chk("t5_rst_stb", stb, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_rdy", req_ready, 0);
    tick(); rst_n = 1; #1;
    chk("t5_restart_rdy", req_ready, 2'b01);
    tick(); req_valid = 2'b00;
    chk("t5_restart_dat", dat_o, 32'h66);
    chk("t5_restart_stb", stb, 1);
    chk("t5_restart_grant", grant, 0);
    ack = 1; tick(); ack = 0;
    chk("t5_wrcnt", wr_cnt, 11);

`ifdef WBM_UART_SCHED_RX_EN
    // irq during pacing: read issued right away
    irq = 1; tick(); irq = 0;
    chk("t6_pre", cyc, 0);
    tick();
    chk("t6_rd", {cyc, stb, we}, 3'b110);
    dat_i = 32'h5A; ack = 1; tick(); ack = 0; dat_i = 0;
    chk("t6_rxv", rx_valid, 1);
    chk("t6_rxd", rx_data, 8'h5A);
    chk("t6_ovr", rx_ovr, 0);
    rx_ready = 1; tick(); rx_ready = 0;
    chk("t6_taken", rx_valid, 0);

    // consumer stalled: deferred read and overrun
    irq = 1; tick(); irq = 0; tick();
    dat_i = 32'h11; ack = 1; tick(); ack = 0; dat_i = 0;
    chk("t7_rxd1", rx_data, 8'h11);
    irq = 1; tick(); irq = 0;
    repeat (3) tick();
    chk("t7_defer", cyc, 0);
    chk("t7_no_ovr", rx_ovr, 0);
    irq = 1; tick(); irq = 0;
    chk("t7_ovr", rx_ovr, 1);
    tick();
    chk("t7_ovr_pulse", rx_ovr, 0);
    chk("t7_hold", rx_data, 8'h11);
    rx_ready = 1; tick(); rx_ready = 0;
    chk("t7_taken", rx_valid, 0);
    tick();
    chk("t7_rd2", {cyc, stb, we}, 3'b110);
    dat_i = 32'h22; ack = 1; tick(); ack = 0; dat_i = 0;
    chk("t7_rxv2", rx_valid, 1);
    chk("t7_rxd2", rx_data, 8'h22);
    repeat (4) tick();
    chk("t7_single", cyc, 0);
    chk("t7_rdcnt", rd_cnt, 3);
`else
    // RX disabled: irq has no effect
    irq = 1; tick(); irq = 0;
    repeat (3) tick();
    chk("t6_cyc", cyc, 0);
    chk("t6_rxv", rx_valid, 0);
    chk("t6_rxd", rx_data, 0);
    irq = 1; tick(); irq = 0;
    chk("t6_ovr", rx_ovr, 0);
    tick();
    chk("t6_rdcnt", rd_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
